// File: rtl/risc16b_mem.sv
// Unified program/data memory for the risc16b core with a length-prefixed byte-stream boot loader.
// Optional memory-mapped output register at 0xFFFE when RISC16B_MEM_GPIO_EN is defined.
module risc16b_mem #(
  parameter int unsigned AW = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        ld_done,
  output logic [15:0] gpio_out
);

  localparam int unsigned Depth  = 1 << AW;
  localparam logic [16:0] DepthW = 17'(Depth);

  typedef enum logic [2:0] {StLenHi, StLenLo, StDatHi, StDatLo, StRun} state_e;

  logic [15:0] mem [Depth];

  state_e      state_q, state_d;
  logic [16:0] wptr_q, wptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hbuf_q, hbuf_d;
  logic        cpu_rst_q, cpu_rst_d;

  logic          i_in_range, d_in_range;
  logic [AW-1:0] i_idx, d_idx;
  logic          ld_we;
  logic          mem_we_hi, mem_we_lo;
  logic [AW-1:0] mem_widx;
  logic [15:0]   mem_wdata;
  logic          core_we_ok;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[0], d_addr[0]};

  assign i_in_range = (i_addr >> (AW + 1)) == 16'd0;
  assign d_in_range = (d_addr >> (AW + 1)) == 16'd0;
  assign i_idx      = i_addr[AW:1];
  assign d_idx      = d_addr[AW:1];
  assign core_we_ok = (state_q == StRun) && !rst;

  // Loader FSM: one byte per cycle, holds whenever ld_valid is low.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    hbuf_d  = hbuf_q;
    ld_we   = 1'b0;
    if (ld_valid) begin
      case (state_q)
        StLenHi: begin
          cnt_d   = {ld_data, cnt_q[7:0]};
          state_d = StLenLo;
        end
        StLenLo: begin
          cnt_d   = {cnt_q[15:8], ld_data};
          state_d = (cnt_d == 16'd0) ? StRun : StDatHi;
        end
        StDatHi: begin
          hbuf_d  = ld_data;
          state_d = StDatLo;
        end
        StDatLo: begin
          // Words past capacity are consumed but dropped; wptr is wide enough never to wrap.
          ld_we   = (wptr_q < DepthW);
          wptr_d  = wptr_q + 17'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? StRun : StDatHi;
        end
        default: ;
      endcase
    end
    cpu_rst_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLenHi;
      wptr_q    <= 17'd0;
      cnt_q     <= 16'd0;
      hbuf_q    <= 8'd0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      hbuf_q    <= hbuf_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Loader and core writes are mutually exclusive: the core is only writable in RUN.
  always_comb begin
    mem_we_hi = 1'b0;
    mem_we_lo = 1'b0;
    mem_widx  = d_idx;
    mem_wdata = d_dout;
    if (ld_we && !rst) begin
      mem_we_hi = 1'b1;
      mem_we_lo = 1'b1;
      mem_widx  = wptr_q[AW-1:0];
      mem_wdata = {hbuf_q, ld_data};
    end else if (core_we_ok && d_in_range) begin
      mem_we_hi = d_we[0];
      mem_we_lo = d_we[1];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[mem_widx][15:8] <= mem_wdata[15:8];
    if (mem_we_lo) mem[mem_widx][7:0]  <= mem_wdata[7:0];
  end

  assign i_din    = (i_oe && i_in_range) ? mem[i_idx] : 16'd0;
  assign ld_ready = (state_q != StRun);
  assign cpu_rst  = cpu_rst_q;
  assign ld_done  = !cpu_rst_q;

`ifdef RISC16B_MEM_GPIO_EN
  logic [15:0] gpio_q, gpio_d;
  logic        gpio_hit;

  assign gpio_hit = (d_addr[15:1] == 15'h7FFF);

  always_comb begin
    gpio_d = gpio_q;
    if (core_we_ok && gpio_hit) begin
      if (d_we[0]) gpio_d[15:8] = d_dout[15:8];
      if (d_we[1]) gpio_d[7:0]  = d_dout[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) gpio_q <= 16'd0;
    else     gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;
  assign d_din    = !d_oe       ? 16'd0 :
                    gpio_hit    ? gpio_q :
                    d_in_range  ? mem[d_idx] : 16'd0;
`else
  assign gpio_out = 16'd0;
  assign d_din    = (d_oe && d_in_range) ? mem[d_idx] : 16'd0;
`endif

endmodule

// File: tb/tb_risc16b_mem.sv
// Scoreboard bench for risc16b_mem: loader, byte lanes, range, overflow, mid-load reset, GPIO.
// A second instance with AW=1 exercises capacity overflow.
module tb_risc16b_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] i_addr, d_addr, d_dout, i_din, d_din, gpio_out;
  logic        i_oe, d_oe, ld_valid, ld_ready, cpu_rst, ld_done;
  logic [1:0]  d_we;
  logic [7:0]  ld_data;

  logic        s_rst, s_ld_valid, s_ld_ready, s_cpu_rst, s_ld_done;
  logic [7:0]  s_ld_data;
  logic [15:0] s_i_addr, s_i_din, s_d_din, s_gpio_out;
  logic [15:0] s_zero16 = 16'd0;
  logic        s_one = 1'b1;
  logic        s_zero = 1'b0;
  logic [1:0]  s_zero2 = 2'd0;

  risc16b_mem #(.AW(14)) u_dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din), .d_dout(d_dout), .d_we(d_we),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_rst(cpu_rst), .ld_done(ld_done), .gpio_out(gpio_out)
  );

  risc16b_mem #(.AW(1)) u_small (
    .clk(clk), .rst(s_rst),
    .i_addr(s_i_addr), .i_oe(s_one), .i_din(s_i_din),
    .d_addr(s_zero16), .d_oe(s_zero), .d_din(s_d_din), .d_dout(s_zero16), .d_we(s_zero2),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_ready(s_ld_ready),
    .cpu_rst(s_cpu_rst), .ld_done(s_ld_done), .gpio_out(s_gpio_out)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [int];
  logic [15:0] gpio_exp;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return i_din;
      1: return d_din;
      2: return {15'd0, cpu_rst};
      3: return {15'd0, ld_ready};
      4: return {15'd0, ld_done};
      5: return gpio_out;
      6: return s_i_din;
      7: return {15'd0, s_ld_ready};
      8: return {15'd0, s_cpu_rst};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic void push(input string n, input int s, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    exp_q.push_back(e);
  endfunction

  task automatic check_now(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // Monitor: combinational outputs settle mid-cycle; compare every queued expectation there.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (actual(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, actual(e.sel), e.exp);
      end
    end
  end

  // Reference model: flat word array, out-of-range reads are zero.
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (a[15]) return 16'd0;
    return ref_mem[int'(a >> 1)];
  endfunction

  function automatic void ref_wr(input logic [15:0] a, input logic [1:0] we, input logic [15:0] v);
    logic [15:0] w;
    if (a[15]) return;
    w = ref_mem.exists(int'(a >> 1)) ? ref_mem[int'(a >> 1)] : 16'd0;
    if (we[0]) w[15:8] = v[15:8];
    if (we[1]) w[7:0]  = v[7:0];
    ref_mem[int'(a >> 1)] = w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    push("ld_ready_busy", 3, 16'd1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b);
    s_ld_valid = 1'b1;
    s_ld_data  = b;
    push("s_ld_ready_busy", 7, 16'd1);
    tick();
    s_ld_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [1:0]  we;
    logic [15:0] v;
    int          wait_n;
    rst = 1'b1; i_addr = 0; d_addr = 0; d_dout = 0; i_oe = 0; d_oe = 0; d_we = 0;
    ld_valid = 0; ld_data = 0;
    s_rst = 1'b1; s_ld_valid = 0; s_ld_data = 0; s_i_addr = 0;
    tick();
    tick();
    check_now("rst_now_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check_now("rst_now_ld_ready", {15'd0, ld_ready}, 16'd1);
    check_now("rst_now_ld_done", {15'd0, ld_done}, 16'd0);
    check_now("rst_now_gpio", gpio_out, 16'd0);
    rst = 1'b0;
    s_rst = 1'b0;
    push("rst_ld_ready", 3, 16'd1);
    push("rst_cpu_rst", 2, 16'd1);
    push("rst_ld_done", 4, 16'd0);
    push("rst_gpio", 5, 16'd0);

    // Load and release, with an idle cycle mid-stream.
    send(8'h00); send(8'h02); send(8'h12);
    tick();
    send(8'h34); send(8'hAB);
    push("cpu_rst_before_last", 2, 16'd1);
    send(8'hCD);
    wait_n = 0;
    while (ld_done !== 1'b1 && wait_n < 4) begin
      tick();
      wait_n++;
    end
    checks++;
    if (ld_done !== 1'b1) begin
      errors++;
      $display("FAIL ld_done_wait: timeout after %0d cycles", wait_n);
    end
    push("cpu_rst_released", 2, 16'd0);
    push("ld_done_run", 4, 16'd1);
    push("ld_ready_run", 3, 16'd0);
    ref_mem[0] = 16'h1234;
    ref_mem[1] = 16'hABCD;
    i_oe = 1'b1; i_addr = 16'h0000;
    push("load_w0", 0, ref_rd(16'h0000));
    tick();
    i_addr = 16'h0002;
    push("load_w1", 0, ref_rd(16'h0002));
    tick();
    i_addr = 16'h0003;
    push("load_w1_odd", 0, ref_rd(16'h0003));
    tick();

    // Zero length image.
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h00);
    push("zl_cpu_rst_hi", 2, 16'd1);
    send(8'h00);
    push("zl_ld_done", 4, 16'd1);
    push("zl_ld_ready", 3, 16'd0);
    i_addr = 16'h0000;
    push("zl_mem0", 0, 16'h1234);
    tick();

    // Byte lanes.
    d_addr = 16'h0100; d_we = 2'b11; d_dout = 16'h0000; ref_wr(d_addr, d_we, d_dout); tick();
    d_we = 2'b01; d_dout = 16'h5A00; ref_wr(d_addr, d_we, d_dout); tick();
    d_oe = 1'b1;
    push("lane_hi", 1, 16'h5A00);
    d_we = 2'b10; d_dout = 16'h00C3; ref_wr(d_addr, d_we, d_dout); tick();
    push("lane_both", 1, 16'h5AC3);
    d_we = 2'b11; d_dout = 16'h1111;
    tick();
    ref_wr(d_addr, 2'b11, 16'h1111);
    d_we = 2'b00;
    push("lane_full_after", 1, 16'h1111);
    tick();

    // Out of range.
    d_addr = 16'h8000; d_we = 2'b11; d_dout = 16'hBEEF; tick();
    d_we = 2'b00;
    push("oor_read", 1, 16'h0000);
    i_addr = 16'h0000;
    push("oor_mem0", 0, 16'h1234);
    tick();
    i_oe = 1'b0; d_oe = 1'b0; d_addr = 16'h0000;
    push("no_oe_i", 0, 16'h0000);
    push("no_oe_d", 1, 16'h0000);
    tick();

    // Output register at 0xFFFE.
`ifdef RISC16B_MEM_GPIO_EN
    gpio_exp = 16'h00FF;
`else
    gpio_exp = 16'h0000;
`endif
    d_addr = 16'hFFFE; d_we = 2'b11; d_dout = 16'h00FF; tick();
    d_we = 2'b00; d_oe = 1'b1; i_oe = 1'b1; i_addr = 16'hFFFE;
    push("gpio_out", 5, gpio_exp);
    push("gpio_read", 1, gpio_exp);
    push("gpio_fetch", 0, 16'h0000);
    tick();
    d_addr = 16'hFFFF;
    push("gpio_read_odd", 1, gpio_exp);
    tick();

    // Randomized core traffic against the model.
    for (int k = 0; k < 32; k++) begin
      d_addr = 16'h0200 + 16'(2 * k); d_we = 2'b11; d_dout = 16'($urandom);
      ref_wr(d_addr, d_we, d_dout);
      tick();
    end
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) a = 16'h8000 | 16'($urandom_range(0, 16'h3000));
      else a = 16'h0200 + 16'(2 * $urandom_range(0, 31)) + 16'($urandom_range(0, 1));
      we = 2'($urandom_range(0, 3));
      v  = 16'($urandom);
      d_addr = a; d_we = we; d_dout = v;
      i_addr = 16'h0200 + 16'($urandom_range(0, 63));
      push("rnd_d", 1, ref_rd(a));
      push("rnd_i", 0, ref_rd(i_addr));
      ref_wr(a, we, v);
      tick();
    end
    d_we = 2'b00;

    // Overflow on AW=1: three words into a two-word memory.
    s_send(8'h00); s_send(8'h03);
    s_send(8'h11); s_send(8'h11); s_send(8'h22); s_send(8'h22); s_send(8'h33);
    push("ovf_cpu_rst_hi", 8, 16'd1);
    s_send(8'h33);
    push("ovf_cpu_rst_lo", 8, 16'd0);
    push("ovf_ld_ready", 7, 16'd0);
    s_i_addr = 16'h0000; push("ovf_w0", 6, 16'h1111); tick();
    s_i_addr = 16'h0002; push("ovf_w1", 6, 16'h2222); tick();
    s_i_addr = 16'h0004; push("ovf_w2_oor", 6, 16'h0000); tick();

    // Reset after three data bytes.
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    s_send(8'h00); s_send(8'h02); s_send(8'h77); s_send(8'h77); s_send(8'h88);
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    push("mid_ld_ready", 7, 16'd1);
    push("mid_cpu_rst", 8, 16'd1);
    s_i_addr = 16'h0000; push("mid_w0", 6, 16'h7777); tick();
    s_i_addr = 16'h0002; push("mid_w1_old", 6, 16'h2222);
    s_send(8'h00);
    push("mid_restart_hi", 8, 16'd1);
    s_send(8'h00);
    push("mid_restart_run", 8, 16'd0);
    tick();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc16b_mem.md
# risc16b_mem

Unified program/data memory responder for the `risc16b` core, with a byte-stream boot loader. It answers the core's instruction-fetch port (`i_*`) and data port (`d_*`) from a single word array, using combinational reads and synchronous byte-lane writes. After reset it holds the core in reset, loads a length-prefixed big-endian image from a byte stream, and then releases the core.

## Interface
- `AW`, default 14: word-address width. The memory holds 2^AW 16-bit words, covering byte addresses 0 to 2^(AW+1)-1. Legal range is 1..14.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `i_addr` input 16: fetch byte address. Bit 0 is ignored.
- `i_oe` input 1: fetch enable.
- `i_din` output 16: fetched word.
- `d_addr` input 16: data byte address. Bit 0 is ignored for the array index.
- `d_oe` input 1: data read enable.
- `d_din` output 16: read data.
- `d_dout` input 16: write data.
- `d_we` input 2: write lane enables. `d_we[0]` writes bits 15:8 (even byte); `d_we[1]` writes bits 7:0 (odd byte).
- `ld_valid` input 1: loader byte valid.
- `ld_data` input 8: loader byte.
- `ld_ready` output 1: loader byte accepted when `ld_valid && ld_ready`.
- `cpu_rst` output 1: reset to the core.
- `ld_done` output 1: high in RUN.
- `gpio_out` output 16: memory-mapped output register (see Configuration).

## Operation
- Array index is `addr[AW:1]`. An address is in range iff `addr[15:AW+1] == 0`.
- Reads are combinational:
  - `i_din = mem[idx]` when `i_oe` and in range, else 0.
  - `d_din` follows the same rule using `d_oe`.
- Data writes:
  - Occur at the clock edge, per lane, only in RUN and only when in range.
  - Out-of-range writes are discarded.
  - Array contents are not cleared by `rst`.
- Loader FSM states: LEN_HI, LEN_LO, DAT_HI, DAT_LO, RUN. `rst` forces LEN_HI, clears `wptr` and `cnt`.
  - LEN_HI: accept byte into `cnt[15:8]`, go to LEN_LO.
  - LEN_LO: accept byte into `cnt[7:0]`. If the full 16-bit count is 0, go to RUN; else go to DAT_HI.
  - DAT_HI: accept byte into `hbuf`, go to DAT_LO.
  - DAT_LO: accept byte. If `wptr < 2^AW`, write `{hbuf, byte}` to `mem[wptr]`; otherwise drop the word. Then `wptr++`, `cnt--`. If `cnt` was 1, go to RUN; else go to DAT_HI.
  - RUN: terminal. Only `rst` leaves it.
- `wptr` is 17 bits wide so it never wraps. Words beyond capacity are consumed and dropped.
- `ld_ready = (state != RUN)`, so one byte is accepted per cycle with no back-pressure.
- `cpu_rst` is a flop loaded with `(next_state != RUN)`. `ld_done` = `!cpu_rst`.
- Core ports are ignored for writes while not in RUN. Reads still respond.

## Timing
- Values after reset: `ld_ready` 1, `cpu_rst` 1, `ld_done` 0, `gpio_out` 0. `i_din`/`d_din` are combinational from the inputs.
- Read latency is 0 cycles. A write is visible to reads from the cycle after the write edge.
- Same-cycle read and write to the same word: the read returns the old data.
- Simultaneous loader write and core access cannot occur, because the core is held in reset until RUN.
- `cpu_rst` falls on the same edge that accepts the last image byte, or the LEN_LO byte when the count is 0. The core's first fetch of address 0 occurs in the following cycle.
- `rst` mid-load: the FSM restarts at LEN_HI. Words already written are retained.
- `ld_valid` low in any loader state: the FSM holds state. There is no timeout.

## Configuration
- `RISC16B_MEM_GPIO_EN` defined:
  - Byte address 0xFFFE is a 16-bit register driving `gpio_out`.
  - The register is written per lane by `d_we` in RUN, and reset to 0.
  - Data reads of 0xFFFE/0xFFFF with `d_oe` return it.
  - Fetches from that address return 0.
- Not defined: `gpio_out` is tied to 0, and 0xFFFE is an ordinary out-of-range address.

## Test plan
- Load and release:
  - Stimulus: reset, then stream 00 02 12 34 AB CD.
  - Required: `mem[0]`=0x1234, `mem[1]`=0xABCD; `cpu_rst` falls on the edge accepting 0xCD; `ld_ready` is 0 afterward; `i_addr`=0x0002 reads 0xABCD.
- Zero length:
  - Stimulus: after the previous test, reset, then stream 00 00.
  - Required: RUN is reached on the second byte, and `mem[0]` still reads 0x1234.
- Byte lanes:
  - Stimulus: in RUN, `d_addr`=0x0100, `d_we`=01, `d_dout`=0x5A00; then `d_we`=10, `d_dout`=0x00C3.
  - Required: a `d_oe` read of 0x0100 returns 0x5AC3, with 0x5A00 visible after the first write. An unwritten `d_we`=11 case returns the prior value on a same-cycle read.
- Out of range:
  - Stimulus: with AW=14, write 0xBEEF at 0x8000, then read 0x8000.
  - Required: `d_din`=0, and `mem[0]` is unchanged. With `i_oe`=0 and `d_oe`=0, both outputs are 0.
- Overflow and mid-load reset:
  - Stimulus: with AW=1, stream length 3 and words 1111 2222 3333.
  - Required: only 2 words are stored, and RUN is reached after byte 8.
  - Stimulus: separately, assert `rst` after 3 data bytes.
  - Required: the FSM is in LEN_HI, `cpu_rst` is 1, and the first word is retained.
- GPIO (macro on):
  - Stimulus: write `d_we`=11, 0x00FF at 0xFFFE.
  - Required: `gpio_out`=0x00FF next cycle, a read returns 0x00FF, and a fetch of 0xFFFE returns 0.
  - Required with the macro off: `gpio_out` stays 0.
